cpu_decode_execute: RTL and testbench
=====================================

# cpu_decode_execute

Decode/execute core of the 5-stage RV32I pipeline. It decodes the instruction in the Decode stage into control signals and latches them in the D→E pipeline register. In Execute it runs the ALU on the forwarded operands and resolves branches and jumps into a next-PC select. Register file, immediate extender, forwarding muxes and hazard detection sit outside this block.

## Interface
- None. The datapath is fixed at 32 bits (RV32I).

- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `flush_e` in 1: at the next edge, load a bubble into the E register instead of the decoded instruction.
- `instr_d` in 32: instruction in Decode.
- `pc_d` in 32: PC of `instr_d`.
- `imm_ext_d` in 32: extended immediate from the external extender.
- `imm_src_d` out 3: combinational immediate format for `instr_d`. Encoding: I=0, S=1, B=2, U=3, J=4.
- `rd1_fw_e`, `rd2_fw_e` in 32: forwarded rs1/rs2 values for the instruction in Execute.
- `reg_write_e` out 1: registered register-file write enable.
- `result_src_e` out 2: registered result select. Encoding: ALU=0, DATA=1, PC_PLUS_4=2, PC_TARGET=3.
- `mem_write_e` out 4: registered byte enables. SB=0001, SH=0011, SW=1111, otherwise 0000.
- `data_ext_control_e` out 3: registered load funct3.
- `illegal_instr_e` out 1: registered illegal-instruction flag.
- `alu_result_e` out 32: combinational ALU result.
- `pc_target_e` out 32: `pc_e + imm_e`, modulo 2^32.
- `pc_src_e` out 2: next-PC select. Encoding: PC+4=0, PC_TARGET=1, ALU=2.

## Operation
- **Decoder control fields.** The combinational decoder produces: `reg_write`, `result_src`, `mem_write`, `jump`, `branch`, `alu_control`, `alu_src_b` (0=rs2, 1=imm), `imm_src`, `data_ext`, `jump_src` (1 for JALR), `branch_cond` (= funct3) and `illegal`.
- **ALU operations by opcode:**
  - OP/OP-IMM: full RV32I set. SRAI requires funct7=0100000; SLLI/SRLI require funct7=0.
  - LOAD/STORE/JALR/JAL: ADD.
  - BRANCH: SUB.
  - LUI: PASS_B with `result_src` ALU.
  - AUIPC: `result_src` PC_TARGET.
  - JAL/JALR: `result_src` PC_PLUS_4.
- **`alu_control` encoding:** ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASS_B 10, MUL 11.
- **Shifts** use `src_b[4:0]` as the shift amount.
- **Illegal instruction:** an unknown opcode, or an invalid funct3/funct7 combination, including SYSTEM. It sets `illegal`=1 and forces `reg_write`, `mem_write`, `jump` and `branch` to 0. FENCE (0001111) decodes as a legal no-op.
- **ALU flags** are internal, computed as `a + ~b + 1` for SUB and as `a + b` for ADD:
  - `zero` = (result == 0).
  - `neg` = result[31].
  - `carry` = bit-33 carry-out; for SUB, 1 means no borrow (a ≥ b unsigned).
  - `overflow` = signed overflow.
  - For every other op, `carry` and `overflow` are 0.
- **Branch conditions:**
  - BEQ: `zero`. BNE: `!zero`.
  - BLT: `neg^overflow`. BGE: its inverse.
  - BLTU: `!carry`. BGEU: `carry`.
  - Reserved funct3 values are illegal at decode.
- **Next-PC select `pc_src_e`:**
  - `jump && jump_src` → ALU.
  - `jump && !jump_src` → PC_TARGET.
  - `branch` with condition true → PC_TARGET.
  - Otherwise → PC+4.
- **JALR target:** the ALU sum is passed unmodified; clearing bit 0 is done downstream.

## Timing
- **D→E register** holds the decoded fields plus `pc_e` and `imm_e`. It loads every rising edge; the block has no stall input.
- **Reset or `flush_e`** loads a bubble: every control field 0 (`alu_control` = ADD, `alu_src_b` = 0, `result_src` = ALU), and `pc_e` = `imm_e` = 0.
  - Reset is asynchronous and takes effect immediately; mid-operation it discards the instruction in E.
  - `rst` takes priority over `flush_e`.
- **Output values after reset:** all registered outputs 0, `pc_src_e` = 0, `pc_target_e` = 0, `alu_result_e` = `rd1_fw_e + rd2_fw_e`.
- **Latency:** decode to E outputs is 1 cycle. `alu_result_e`, `pc_target_e` and `pc_src_e` are combinational from the E register and the forwarded operands, all in the same cycle.
- `imm_src_d` is purely combinational from `instr_d`.

## Configuration
- `CPU_MUL_EN` defined: OP with funct7=0000001 and funct3=000 decodes as MUL, `alu_control` 11, producing the low 32 bits of the product. Its flags are zero/neg only.
- `CPU_MUL_EN` undefined: any funct7=0000001 instruction is illegal.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `reg_write_e`, `mem_write_e`, `illegal_instr_e` and `pc_src_e` go to 0 immediately.
- **ADDI:** `instr_d`=0x00500093, `imm_ext_d`=5, then one edge with `rd1_fw_e`=0 → `reg_write_e`=1, `result_src_e`=0, `alu_result_e`=5, `pc_src_e`=0.
- **BEQ:** `instr_d`=0x00208463, `pc_d`=0x100, `imm`=8.
  - `rd1`=`rd2`=7 → `pc_src_e`=1, `pc_target_e`=0x108.
  - `rd2`=8 → `pc_src_e`=0.
- **Signed vs unsigned:** `rd1`=1, `rd2`=0xFFFFFFFF → BLTU taken (`pc_src_e`=1); BLT not taken (`pc_src_e`=0).
- **JALR:** `instr_d`=0x000080E7, `rd1`=0x200, `imm`=0 → `pc_src_e`=2, `alu_result_e`=0x200, `result_src_e`=2.
- **Illegal and flush:**
  - `instr_d`=0xFFFFFFFF → `illegal_instr_e`=1, `reg_write_e`=0, `mem_write_e`=0.
  - SW with `flush_e`=1 → `mem_write_e`=0.
  - MUL (0x02208033) → illegal without `CPU_MUL_EN`; with it, `rd1`=6, `rd2`=7 → `alu_result_e`=42.

Source files
------------

// File: rtl/cpu_decode_execute_if.sv
// Decode/execute bus: D-stage instruction inputs, E-stage forwarded operands and E-stage results.
// The master side drives the pipeline inputs; the slave side is the decode/execute core.
interface cpu_decode_execute_if;
    logic        flush_e;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] imm_ext_d;
    logic [2:0]  imm_src_d;
    logic [31:0] rd1_fw_e;
    logic [31:0] rd2_fw_e;
    logic        reg_write_e;
    logic [1:0]  result_src_e;
    logic [3:0]  mem_write_e;
    logic [2:0]  data_ext_control_e;
    logic        illegal_instr_e;
    logic [31:0] alu_result_e;
    logic [31:0] pc_target_e;
    logic [1:0]  pc_src_e;

    modport master (
        output flush_e, instr_d, pc_d, imm_ext_d, rd1_fw_e, rd2_fw_e,
        input  imm_src_d, reg_write_e, result_src_e, mem_write_e, data_ext_control_e,
               illegal_instr_e, alu_result_e, pc_target_e, pc_src_e
    );

    modport slave (
        input  flush_e, instr_d, pc_d, imm_ext_d, rd1_fw_e, rd2_fw_e,
        output imm_src_d, reg_write_e, result_src_e, mem_write_e, data_ext_control_e,
               illegal_instr_e, alu_result_e, pc_target_e, pc_src_e
    );
endinterface

// File: rtl/cpu_decode_execute.sv
// RV32I decode + D->E register + execute (ALU, branch/jump resolution).
// Define CPU_MUL_EN to decode OP funct7=0000001/funct3=000 as MUL (low 32 bits).
module cpu_decode_execute (
    input  logic                 clk,
    input  logic                 rst,
    cpu_decode_execute_if.slave  bus
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_PASS_B = 4'd10, ALU_MUL = 4'd11;

    localparam logic [1:0] RES_DATA = 2'd1, RES_PC4 = 2'd2, RES_PCT = 2'd3;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
    localparam logic [1:0] PCS_PC4 = 2'd0, PCS_TARGET = 2'd1, PCS_ALU = 2'd2;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic [3:0] mem_write;
        logic       jump;
        logic       branch;
        logic [3:0] alu_control;
        logic       alu_src_b;
        logic [2:0] data_ext;
        logic       jump_src;
        logic [2:0] branch_cond;
        logic       illegal;
    } ctrl_t;

    ctrl_t       dec;
    ctrl_t       ctrl_d, ctrl_q;
    logic [31:0] pc_e_d, pc_e_q, imm_e_d, imm_e_q;
    logic [2:0]  imm_src;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       unused_fields;

    assign opcode        = bus.instr_d[6:0];
    assign funct3        = bus.instr_d[14:12];
    assign funct7        = bus.instr_d[31:25];
    assign unused_fields = ^{bus.instr_d[24:15], bus.instr_d[11:7]};

    always_comb begin
        dec     = '0;
        imm_src = IMM_I;
        unique case (opcode)
            OPC_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.result_src = RES_DATA;
                dec.alu_src_b  = 1'b1;
                dec.data_ext   = funct3;
                dec.illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                imm_src       = IMM_S;
                dec.alu_src_b = 1'b1;
                case (funct3)
                    3'b000:  dec.mem_write = 4'b0001;
                    3'b001:  dec.mem_write = 4'b0011;
                    3'b010:  dec.mem_write = 4'b1111;
                    default: dec.illegal   = 1'b1;
                endcase
            end
            OPC_OPIMM, OPC_OP: begin
                dec.reg_write = 1'b1;
                dec.alu_src_b = (opcode == OPC_OPIMM);
                case (funct3)
                    3'b000:  dec.alu_control = ALU_ADD;
                    3'b001:  dec.alu_control = ALU_SLL;
                    3'b010:  dec.alu_control = ALU_SLT;
                    3'b011:  dec.alu_control = ALU_SLTU;
                    3'b100:  dec.alu_control = ALU_XOR;
                    3'b101:  dec.alu_control = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
                    3'b110:  dec.alu_control = ALU_OR;
                    default: dec.alu_control = ALU_AND;
                endcase
                // I-type only constrains funct7 for shifts; R-type needs funct7=0 except SUB/SRA/MUL.
                if (opcode == OPC_OPIMM) begin
                    if (funct3 == 3'b001)
                        dec.illegal = (funct7 != 7'b0000000);
                    else if (funct3 == 3'b101)
                        dec.illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)
                        dec.alu_control = ALU_SUB;
                    else
                        dec.illegal = (funct3 != 3'b101);
                end else if (funct7 == 7'b0000001) begin
`ifdef CPU_MUL_EN
                    dec.alu_control = ALU_MUL;
                    dec.illegal     = (funct3 != 3'b000);
`else
                    dec.illegal     = 1'b1;
`endif
                end else begin
                    dec.illegal = (funct7 != 7'b0000000);
                end
            end
            OPC_LUI: begin
                imm_src         = IMM_U;
                dec.reg_write   = 1'b1;
                dec.alu_control = ALU_PASS_B;
                dec.alu_src_b   = 1'b1;
            end
            OPC_AUIPC: begin
                imm_src        = IMM_U;
                dec.reg_write  = 1'b1;
                dec.result_src = RES_PCT;
            end
            OPC_JAL: begin
                imm_src        = IMM_J;
                dec.reg_write  = 1'b1;
                dec.result_src = RES_PC4;
                dec.jump       = 1'b1;
            end
            OPC_JALR: begin
                dec.reg_write  = 1'b1;
                dec.result_src = RES_PC4;
                dec.jump       = 1'b1;
                dec.jump_src   = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.illegal    = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                imm_src         = IMM_B;
                dec.branch      = 1'b1;
                dec.alu_control = ALU_SUB;
                dec.branch_cond = funct3;
                dec.illegal     = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_FENCE: ;
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    always_comb begin
        ctrl_d  = bus.flush_e ? '0 : dec;
        pc_e_d  = bus.flush_e ? '0 : bus.pc_d;
        imm_e_d = bus.flush_e ? '0 : bus.imm_ext_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            pc_e_q  <= '0;
            imm_e_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            pc_e_q  <= pc_e_d;
            imm_e_q <= imm_e_d;
        end
    end

    logic [31:0] src_a, src_b, add_b, alu_res;
    logic [32:0] sum;
    logic        is_sub, zero, neg, carry, overflow, taken;

    always_comb begin
        src_a    = bus.rd1_fw_e;
        src_b    = ctrl_q.alu_src_b ? imm_e_q : bus.rd2_fw_e;
        is_sub   = (ctrl_q.alu_control == ALU_SUB);
        add_b    = is_sub ? ~src_b : src_b;
        sum      = {1'b0, src_a} + {1'b0, add_b} + {32'd0, is_sub};
        carry    = 1'b0;
        overflow = 1'b0;
        case (ctrl_q.alu_control)
            ALU_ADD, ALU_SUB: begin
                alu_res  = sum[31:0];
                carry    = sum[32];
                overflow = (src_a[31] == add_b[31]) && (sum[31] != src_a[31]);
            end
            ALU_AND:    alu_res = src_a & src_b;
            ALU_OR:     alu_res = src_a | src_b;
            ALU_XOR:    alu_res = src_a ^ src_b;
            ALU_SLL:    alu_res = src_a << src_b[4:0];
            ALU_SRL:    alu_res = src_a >> src_b[4:0];
            ALU_SRA:    alu_res = $unsigned($signed(src_a) >>> src_b[4:0]);
            ALU_SLT:    alu_res = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            ALU_SLTU:   alu_res = (src_a < src_b) ? 32'd1 : 32'd0;
            ALU_PASS_B: alu_res = src_b;
`ifdef CPU_MUL_EN
            ALU_MUL:    alu_res = src_a * src_b;
`endif
            default:    alu_res = sum[31:0];
        endcase
        zero = (alu_res == '0);
        neg  = alu_res[31];

        case (ctrl_q.branch_cond)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = neg ^ overflow;
            3'b101:  taken = !(neg ^ overflow);
            3'b110:  taken = !carry;
            3'b111:  taken = carry;
            default: taken = 1'b0;
        endcase

        if (ctrl_q.jump && ctrl_q.jump_src)
            bus.pc_src_e = PCS_ALU;
        else if (ctrl_q.jump || (ctrl_q.branch && taken))
            bus.pc_src_e = PCS_TARGET;
        else
            bus.pc_src_e = PCS_PC4;
    end

    assign bus.imm_src_d          = imm_src;
    assign bus.reg_write_e        = ctrl_q.reg_write;
    assign bus.result_src_e       = ctrl_q.result_src;
    assign bus.mem_write_e        = ctrl_q.mem_write;
    assign bus.data_ext_control_e = ctrl_q.data_ext;
    assign bus.illegal_instr_e    = ctrl_q.illegal;
    assign bus.alu_result_e       = alu_res;
    assign bus.pc_target_e        = pc_e_q + imm_e_q;
endmodule

// File: tb/tb_cpu_decode_execute.sv
// Directed and randomized checks of cpu_decode_execute against an
// instruction-level reference model (results computed from RV32I semantics).
module tb_cpu_decode_execute;
    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    cpu_decode_execute_if bus ();
    cpu_decode_execute dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic [3:0]  mem_write;
        logic        illegal;
        logic [31:0] alu;
        logic        chk_alu;
        logic [1:0]  pc_src;
        logic [31:0] pc_target;
        logic [2:0]  imm_src;
        logic        chk_imm;
        logic [2:0]  dext;
        logic        chk_dext;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arithmetic/logic result of OP and OP-IMM; bit 32 flags a legal encoding.
    function automatic logic [32:0] alu_ref(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic is_imm, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (f3)
            3'd0: begin
                if (is_imm || f7 == 7'h00) return {1'b1, a + b};
                if (f7 == 7'h20)           return {1'b1, a - b};
`ifdef CPU_MUL_EN
                if (f7 == 7'h01)           return {1'b1, a * b};
`endif
                return '0;
            end
            3'd1: return {f7 == 7'h00, a << sh};
            3'd2: return {is_imm || f7 == 7'h00, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
            3'd3: return {is_imm || f7 == 7'h00, (a < b) ? 32'd1 : 32'd0};
            3'd4: return {is_imm || f7 == 7'h00, a ^ b};
            3'd5: begin
                if (f7 == 7'h00) return {1'b1, a >> sh};
                if (f7 == 7'h20) return {1'b1, $unsigned($signed(a) >>> sh)};
                return '0;
            end
            3'd6: return {is_imm || f7 == 7'h00, a | b};
            default: return {is_imm || f7 == 7'h00, a & b};
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm,
                                   input logic [31:0] a, input logic [31:0] b2, input logic flush);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [32:0] r;
        logic        ok;
        e  = '0;
        op = ins[6:0];
        f3 = ins[14:12];
        ok = 1'b1;
        e.pc_target = pc + imm;
        case (op)
            7'h03: begin
                ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                e.reg_write = 1; e.result_src = 1; e.alu = a + imm; e.chk_alu = 1;
                e.dext = f3; e.chk_dext = 1; e.imm_src = 0; e.chk_imm = 1;
            end
            7'h23: begin
                ok = (f3 <= 3'd2);
                e.mem_write = (f3 == 0) ? 4'h1 : (f3 == 1) ? 4'h3 : 4'hF;
                e.alu = a + imm; e.chk_alu = 1; e.imm_src = 1; e.chk_imm = 1;
            end
            7'h13, 7'h33: begin
                r = alu_ref(f3, ins[31:25], op == 7'h13, a, (op == 7'h13) ? imm : b2);
                ok = r[32];
                e.reg_write = 1; e.alu = r[31:0]; e.chk_alu = 1;
                e.imm_src = 0; e.chk_imm = (op == 7'h13);
            end
            7'h37: begin e.reg_write = 1; e.alu = imm; e.chk_alu = 1; e.imm_src = 3; e.chk_imm = 1; end
            7'h17: begin e.reg_write = 1; e.result_src = 3; e.imm_src = 3; e.chk_imm = 1; end
            7'h6F: begin e.reg_write = 1; e.result_src = 2; e.pc_src = 1; e.imm_src = 4; e.chk_imm = 1; end
            7'h67: begin
                ok = (f3 == 0);
                e.reg_write = 1; e.result_src = 2; e.pc_src = 2; e.alu = a + imm; e.chk_alu = 1;
                e.imm_src = 0; e.chk_imm = 1;
            end
            7'h63: begin
                ok = !(f3 inside {3'd2, 3'd3});
                case (f3)
                    3'd0: e.pc_src = {1'b0, a == b2};
                    3'd1: e.pc_src = {1'b0, a != b2};
                    3'd4: e.pc_src = {1'b0, $signed(a) < $signed(b2)};
                    3'd5: e.pc_src = {1'b0, $signed(a) >= $signed(b2)};
                    3'd6: e.pc_src = {1'b0, a < b2};
                    default: e.pc_src = {1'b0, a >= b2};
                endcase
                e.alu = a - b2; e.chk_alu = 1; e.imm_src = 2; e.chk_imm = 1;
            end
            7'h0F: ;
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.reg_write = 0; e.result_src = 0; e.mem_write = 0; e.pc_src = 0;
            e.illegal = 1; e.chk_alu = 0; e.chk_imm = 0; e.chk_dext = 0;
        end
        if (flush) begin
            e.reg_write = 0; e.result_src = 0; e.mem_write = 0; e.illegal = 0; e.pc_src = 0;
            e.pc_target = 0; e.alu = a + b2; e.chk_alu = 1; e.dext = 0; e.chk_dext = 1;
        end
        return e;
    endfunction

    task automatic drive_d(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm, input logic flush);
        @(negedge clk);
        bus.instr_d = ins; bus.pc_d = pc; bus.imm_ext_d = imm; bus.flush_e = flush;
        #1;
    endtask

    task automatic clock_e(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.rd1_fw_e = a; bus.rd2_fw_e = b;
        #1;
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_async_rw", {31'd0, bus.reg_write_e}, 32'd0);
        check("rst_async_mw", {28'd0, bus.mem_write_e}, 32'd0);
        check("rst_async_ill", {31'd0, bus.illegal_instr_e}, 32'd0);
        check("rst_async_pcsrc", {30'd0, bus.pc_src_e}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        exp_t        e;
        logic [31:0] ins, pc, imm, a, b2, r;
        logic [6:0]  op, f7;
        logic        fl;

        rst = 1'b0;
        bus.flush_e = 0; bus.instr_d = '0; bus.pc_d = '0; bus.imm_ext_d = '0;
        bus.rd1_fw_e = 32'd3; bus.rd2_fw_e = 32'd4;
        #1 rst = 1'b1;
        #2;
        check("reset_rw", {31'd0, bus.reg_write_e}, 32'd0);
        check("reset_rs", {30'd0, bus.result_src_e}, 32'd0);
        check("reset_mw", {28'd0, bus.mem_write_e}, 32'd0);
        check("reset_dext", {29'd0, bus.data_ext_control_e}, 32'd0);
        check("reset_ill", {31'd0, bus.illegal_instr_e}, 32'd0);
        check("reset_pcsrc", {30'd0, bus.pc_src_e}, 32'd0);
        check("reset_pct", bus.pc_target_e, 32'd0);
        check("reset_alu", bus.alu_result_e, 32'd7);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset discards whatever sits in E.
        drive_d(32'h0020A023, 32'h40, 32'h0, 0);
        clock_e(32'h0, 32'h0);
        check("sw_mw", {28'd0, bus.mem_write_e}, 32'hF);
        mid_reset();
        drive_d(32'hFFFFFFFF, 32'h44, 32'h0, 0);
        clock_e(32'h0, 32'h0);
        check("ill_loaded", {31'd0, bus.illegal_instr_e}, 32'd1);
        mid_reset();
        drive_d(32'h0080006F, 32'h48, 32'h8, 0);
        check("jal_imm_src", {29'd0, bus.imm_src_d}, 32'd4);
        clock_e(32'h0, 32'h0);
        check("jal_pcsrc", {30'd0, bus.pc_src_e}, 32'd1);
        check("jal_rw", {31'd0, bus.reg_write_e}, 32'd1);
        mid_reset();

        drive_d(32'h00500093, 32'h0, 32'd5, 0);
        check("addi_imm_src", {29'd0, bus.imm_src_d}, 32'd0);
        clock_e(32'd0, 32'h1234);
        check("addi_rw", {31'd0, bus.reg_write_e}, 32'd1);
        check("addi_rs", {30'd0, bus.result_src_e}, 32'd0);
        check("addi_alu", bus.alu_result_e, 32'd5);
        check("addi_pcsrc", {30'd0, bus.pc_src_e}, 32'd0);

        drive_d(32'h00208463, 32'h100, 32'd8, 0);
        check("beq_imm_src", {29'd0, bus.imm_src_d}, 32'd2);
        clock_e(32'd7, 32'd7);
        check("beq_taken", {30'd0, bus.pc_src_e}, 32'd1);
        check("beq_target", bus.pc_target_e, 32'h108);
        bus.rd2_fw_e = 32'd8;
        #1;
        check("beq_not_taken", {30'd0, bus.pc_src_e}, 32'd0);

        drive_d(32'h0020E463, 32'h200, 32'd16, 0);
        clock_e(32'd1, 32'hFFFFFFFF);
        check("bltu_taken", {30'd0, bus.pc_src_e}, 32'd1);
        drive_d(32'h0020C463, 32'h200, 32'd16, 0);
        clock_e(32'd1, 32'hFFFFFFFF);
        check("blt_not_taken", {30'd0, bus.pc_src_e}, 32'd0);

        drive_d(32'h000080E7, 32'h300, 32'd0, 0);
        clock_e(32'h200, 32'h55);
        check("jalr_pcsrc", {30'd0, bus.pc_src_e}, 32'd2);
        check("jalr_alu", bus.alu_result_e, 32'h200);
        check("jalr_rs", {30'd0, bus.result_src_e}, 32'd2);

        drive_d(32'hFFFFFFFF, 32'h0, 32'h0, 0);
        clock_e(32'h0, 32'h0);
        check("illegal_flag", {31'd0, bus.illegal_instr_e}, 32'd1);
        check("illegal_rw", {31'd0, bus.reg_write_e}, 32'd0);
        check("illegal_mw", {28'd0, bus.mem_write_e}, 32'd0);

        drive_d(32'h0020A023, 32'h80, 32'h4, 1);
        clock_e(32'h0, 32'h0);
        check("flush_mw", {28'd0, bus.mem_write_e}, 32'd0);
        check("flush_pct", bus.pc_target_e, 32'd0);

        drive_d(32'h02208033, 32'h0, 32'h0, 0);
        clock_e(32'd6, 32'd7);
`ifdef CPU_MUL_EN
        check("mul_ill", {31'd0, bus.illegal_instr_e}, 32'd0);
        check("mul_alu", bus.alu_result_e, 32'd42);
`else
        check("mul_ill", {31'd0, bus.illegal_instr_e}, 32'd1);
        check("mul_rw", {31'd0, bus.reg_write_e}, 32'd0);
`endif

        for (int unsigned i = 0; i < 400; i++) begin
            case ($urandom_range(0, 11))
                0: op = 7'h03;  1: op = 7'h13;  2: op = 7'h17;  3: op = 7'h23;
                4: op = 7'h33;  5: op = 7'h37;  6: op = 7'h63;  7: op = 7'h67;
                8: op = 7'h6F;  9: op = 7'h0F;  10: op = 7'h73;
                default: op = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;  1: f7 = 7'h20;  2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            r   = $urandom;
            ins = {f7, r[24:15], 3'($urandom), r[11:7], op};
            pc  = $urandom;
            imm = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 64);
            a   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom;
            b2  = ($urandom_range(0, 2) == 0) ? a : ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            fl  = ($urandom_range(0, 7) == 0);
            e   = model(ins, pc, imm, a, b2, fl);
            drive_d(ins, pc, imm, fl);
            if (e.chk_imm) check("rand_imm_src", {29'd0, bus.imm_src_d}, {29'd0, e.imm_src});
            clock_e(a, b2);
            check("rand_rw", {31'd0, bus.reg_write_e}, {31'd0, e.reg_write});
            check("rand_rs", {30'd0, bus.result_src_e}, {30'd0, e.result_src});
            check("rand_mw", {28'd0, bus.mem_write_e}, {28'd0, e.mem_write});
            check("rand_ill", {31'd0, bus.illegal_instr_e}, {31'd0, e.illegal});
            check("rand_pcsrc", {30'd0, bus.pc_src_e}, {30'd0, e.pc_src});
            check("rand_pct", bus.pc_target_e, e.pc_target);
            if (e.chk_alu) check("rand_alu", bus.alu_result_e, e.alu);
            if (e.chk_dext) check("rand_dext", {29'd0, bus.data_ext_control_e}, {29'd0, e.dext});
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
